// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32 x XLEN integer register file with x0 tied to zero,
// two combinational decode read ports and a committed-write counter.
// Optional macro WB_BYPASS_EN forwards a same-cycle W-stage write to the read ports.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWriteW,
    input  logic [1:0]       resultSrcW,
    input  logic [4:0]       RdW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [XLEN-1:0]  extImmW,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] wbCount
);

    localparam int NREGS = 32;
    localparam int NPORTS = 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Entry 0 is only ever cleared; reads of index 0 are forced to zero regardless.
    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [CNT_W-1:0] wb_count_reg;
    logic [XLEN-1:0]  result_next;
    logic             commit_next;

    always_comb begin
        result_next = ALUResultW;
        unique case (resultSrcW)
            2'b00: result_next = ALUResultW;
            2'b01: result_next = ReadDataW;
            2'b10: result_next = PCPlus4W;
            2'b11: result_next = extImmW;
            default: result_next = ALUResultW;
        endcase
    end

    assign commit_next = regWriteW && (RdW != 5'd0);

    // Reset takes priority over a simultaneous commit, discarding the in-flight write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
            wb_count_reg <= '0;
        end else if (commit_next) begin
            regs_reg[RdW] <= result_next;
            wb_count_reg  <= wb_count_reg + CNT_ONE;
        end
    end

    logic [4:0]      rs_idx  [NPORTS];
    logic [XLEN-1:0] rd_data [NPORTS];

    assign rs_idx[0] = Rs1D;
    assign rs_idx[1] = Rs2D;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                if (rs_idx[gi] != 5'd0) begin
`ifdef WB_BYPASS_EN
                    if (rst) begin
                        rd_data[gi] = '0;
                    end else if (commit_next && (rs_idx[gi] == RdW)) begin
                        rd_data[gi] = result_next;
                    end else begin
                        rd_data[gi] = regs_reg[rs_idx[gi]];
                    end
`else
                    rd_data[gi] = regs_reg[rs_idx[gi]];
`endif
                end
            end
        end
    endgenerate

    assign RD1D    = rd_data[0];
    assign RD2D    = rd_data[1];
    assign ResultW = result_next;
    assign wbCount = wb_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks plus randomized traffic compared every
// cycle against an array/counter model; a CNT_W=4 twin shares the inputs to exercise wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteW;
    logic [1:0]  resultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, extImmW;
    logic [4:0]  Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [31:0] wbCount;
    logic [31:0] RD1D_4, RD2D_4, ResultW_4;
    logic [3:0]  wbCount_4;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_cnt;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .regWriteW(regWriteW), .resultSrcW(resultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .extImmW(extImmW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .wbCount(wbCount)
    );

    wb_regfile #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .regWriteW(regWriteW), .resultSrcW(resultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .extImmW(extImmW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D_4), .RD2D(RD2D_4), .ResultW(ResultW_4),
        .wbCount(wbCount_4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_result();
        case (resultSrcW)
            2'd0: return ALUResultW;
            2'd1: return ReadDataW;
            2'd2: return PCPlus4W;
            default: return extImmW;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (rst) return 32'd0;
        if (regWriteW && RdW != 5'd0 && rs == RdW) return exp_result();
`endif
        return model_regs[rs];
    endfunction

    // Architectural model: what the register file must hold after each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
            model_cnt   <= 32'd0;
            model_valid <= 1'b1;
        end else if (model_valid && regWriteW && RdW != 5'd0) begin
            model_regs[RdW] <= exp_result();
            model_cnt       <= model_cnt + 32'd1;
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ResultW", ResultW, exp_result());
            check("RD1D", RD1D, exp_read(Rs1D));
            check("RD2D", RD2D, exp_read(Rs2D));
            check("wbCount", wbCount, model_cnt);
            check("ResultW_4", ResultW_4, exp_result());
            check("RD1D_4", RD1D_4, exp_read(Rs1D));
            check("RD2D_4", RD2D_4, exp_read(Rs2D));
            check("wbCount_4", {28'd0, wbCount_4}, model_cnt & 32'hF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [4:0] rs1, input logic [4:0] rs2);
        rst = r; regWriteW = we; resultSrcW = src; RdW = rd; ALUResultW = alu;
        Rs1D = rs1; Rs2D = rs2;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        ReadDataW = 32'd0; PCPlus4W = 32'd0; extImmW = 32'd0;
        tick(); tick();

        // Reset: preload x5, then reset over a pending write to x6.
        drive(1'b0, 1'b1, 2'd0, 5'd5, 32'h1234, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd5, 5'd0);
        @(negedge clk);
        check("preload_x5", RD1D, 32'h1234);
        check("preload_cnt", wbCount, 32'd1);
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd6, 32'h9999, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd5, 5'd6);
        @(negedge clk);
        check("reset_x5", RD1D, 32'd0);
        check("reset_x6", RD2D, 32'd0);
        check("reset_cnt", wbCount, 32'd0);
        tick();

        // Result select sweep into x1..x4.
        ReadDataW = 32'hB; PCPlus4W = 32'hC; extImmW = 32'hD;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 5'(i + 1), 32'hA, 5'd0, 5'd0);
            @(negedge clk);
            check("sel_result", ResultW, 32'hA + 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'hA, 5'd1, 5'd2);
        @(negedge clk);
        check("sel_x1", RD1D, 32'hA);
        check("sel_x2", RD2D, 32'hB);
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'hA, 5'd3, 5'd4);
        @(negedge clk);
        check("sel_x3", RD1D, 32'hC);
        check("sel_x4", RD2D, 32'hD);
        check("sel_cnt", wbCount, 32'd4);
        tick();

        // x0 protection.
        drive(1'b0, 1'b1, 2'd0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("x0_read", RD1D, 32'd0);
        check("x0_cnt", wbCount, 32'd4);
        tick();

        // Same-cycle hazard on x7.
        drive(1'b0, 1'b1, 2'd0, 5'd7, 32'h11, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 2'd0, 5'd7, 32'h22, 5'd7, 5'd7);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("hazard_rd1", RD1D, 32'h22);
        check("hazard_rd2", RD2D, 32'h22);
`else
        check("hazard_rd1", RD1D, 32'h11);
        check("hazard_rd2", RD2D, 32'h11);
`endif
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd7, 5'd7);
        @(negedge clk);
        check("hazard_next", RD1D, 32'h22);
        check("hazard_cnt", wbCount, 32'd6);
        tick();

        // Disabled write.
        drive(1'b0, 1'b0, 2'd0, 5'd9, 32'h55, 5'd0, 5'd0);
        @(negedge clk);
        check("dis_result", ResultW, 32'h55);
        tick();
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd9, 5'd0);
        @(negedge clk);
        check("dis_x9", RD1D, 32'd0);
        check("dis_cnt", wbCount, 32'd6);
        tick();

        // Wrap of the 4-bit counter: 10 more commits bring it from 6 to 16 -> 0.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 2'd0, 5'(10 + i), 32'(100 + i), 5'd0, 5'd0);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd10, 5'd19);
        @(negedge clk);
        check("wrap_cnt4", {28'd0, wbCount_4}, 32'd0);
        check("wrap_cnt32", wbCount, 32'd16);
        check("wrap_x19", RD2D, 32'd109);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            regWriteW  = ($urandom_range(0, 3) != 0);
            resultSrcW = 2'($urandom_range(0, 3));
            RdW        = ($urandom_range(0, 3) == 0) ? Rs1D : 5'($urandom);
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            extImmW    = $urandom;
            Rs1D       = 5'($urandom);
            Rs2D       = ($urandom_range(0, 2) == 0) ? RdW : 5'($urandom);
            tick();
        end

        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
